// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus between the two-requester arbiter and the slave side
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_W-1:0]     PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PSLVERR, PRDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter placing two requesters onto one APB master port
module apb_master_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 m0_req,
    input  logic [ADDR_W-1:0]    m0_addr,
    input  logic                 m0_write,
    input  logic [DATA_W-1:0]    m0_wdata,
    input  logic [DATA_W/8-1:0]  m0_strb,
    output logic                 m0_done,
    output logic [DATA_W-1:0]    m0_rdata,
    output logic                 m0_err,
    input  logic                 m1_req,
    input  logic [ADDR_W-1:0]    m1_addr,
    input  logic                 m1_write,
    input  logic [DATA_W-1:0]    m1_wdata,
    input  logic [DATA_W/8-1:0]  m1_strb,
    output logic                 m1_done,
    output logic [DATA_W-1:0]    m1_rdata,
    output logic                 m1_err,
    apb_master_arbiter_if.master apb
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

    logic [1:0]          state;
    logic                grant;
    logic                last_grant;
    logic [7:0]          wait_cnt;

    logic                pick;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_strb;
    logic                finish;
    logic                fin_err;
    logic [DATA_W-1:0]   fin_rdata;

    // With both requesting, the one not served last wins; a lone requester always wins.
    always_comb begin
        pick      = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel_write = pick ? m1_write : m0_write;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_strb  = pick ? m1_strb  : m0_strb;
    end

    // A timeout abort looks like a completion that carries err=1 and no data.
    always_comb begin
        finish    = (state == ACCESS) && (apb.PREADY || (wait_cnt == WAIT_MAX));
        fin_err   = apb.PREADY ? apb.PSLVERR : 1'b1;
        fin_rdata = (apb.PREADY && !apb.PWRITE) ? apb.PRDATA : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
            m0_done     <= 1'b0;
            m0_rdata    <= '0;
            m0_err      <= 1'b0;
            m1_done     <= 1'b0;
            m1_rdata    <= '0;
            m1_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        wait_cnt    <= '0;
                        apb.PSEL    <= 1'b1;
                        apb.PENABLE <= 1'b0;
                        apb.PWRITE  <= sel_write;
                        apb.PADDR   <= sel_addr;
                        apb.PWDATA  <= sel_wdata;
                        apb.PSTRB   <= sel_write ? sel_strb : '0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        if (grant) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= fin_rdata;
                            m1_err   <= fin_err;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= fin_rdata;
                            m0_err   <= fin_err;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    m0_done  <= 1'b0;
                    m0_rdata <= '0;
                    m0_err   <= 1'b0;
                    m1_done  <= 1'b0;
                    m1_rdata <= '0;
                    m1_err   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter against a behavioural model
module tb_apb_master_arbiter;
    localparam int TOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        m0_req, m0_write, m0_done, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_strb;
    logic        m1_req, m1_write, m1_done, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_strb;

    apb_master_arbiter_if bus ();

    apb_master_arbiter dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
        .m0_strb(m0_strb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
        .m1_strb(m1_strb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .apb(bus)
    );

    always #5 PCLK = ~PCLK;

    int          errors = 0;
    int          checks = 0;
    int          slave_waits = 0;
    logic [31:0] slave_rdata = 32'h0;
    logic        slave_err = 1'b0;
    int          model_last = 1;
    int          obs_order[$];
    int          setup_order[$];
    int          exp_order[$];
    int          rr_bad;

    // Slave: holds PREADY low for slave_waits ACCESS cycles, then raises it.
    initial begin
        int acc;
        acc = 0;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY = (acc >= slave_waits);
                acc++;
            end else begin
                bus.PREADY = 1'b0;
                acc = 0;
            end
            bus.PRDATA  = slave_rdata;
            bus.PSLVERR = slave_err;
        end
    end

    function automatic int exp_acc_len(input int waits);
        return (waits + 1 < TOUT) ? waits + 1 : TOUT;
    endfunction

    task automatic single(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int waits, input logic [31:0] rd, input logic se,
                          output int t_sel, output int t_en, output int t_done, output int acc_len,
                          output logic [31:0] o_rdata, output logic o_err, output logic o_bad,
                          output logic o_psel_done, output logic [31:0] o_paddr,
                          output logic [3:0] o_pstrb, output logic [31:0] o_pwdata, output logic o_pwrite);
        @(negedge PCLK);
        slave_waits = waits; slave_rdata = rd; slave_err = se;
        if (m == 0) begin
            m0_write = wr; m0_addr = a; m0_wdata = d; m0_strb = s; m0_req = 1'b1;
        end else begin
            m1_write = wr; m1_addr = a; m1_wdata = d; m1_strb = s; m1_req = 1'b1;
        end
        t_sel = -1; t_en = -1; t_done = -1; acc_len = 0;
        o_rdata = '0; o_err = 1'b0; o_bad = 1'b0; o_psel_done = 1'b0;
        o_paddr = '0; o_pstrb = '0; o_pwdata = '0; o_pwrite = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (bus.PSEL && t_sel < 0) begin
                t_sel = c; o_paddr = bus.PADDR; o_pstrb = bus.PSTRB;
                o_pwdata = bus.PWDATA; o_pwrite = bus.PWRITE;
            end
            if (bus.PSEL && {bus.PADDR, bus.PSTRB, bus.PWDATA, bus.PWRITE} !== {o_paddr, o_pstrb, o_pwdata, o_pwrite})
                o_bad = 1'b1;
            if (bus.PENABLE && t_en < 0) t_en = c;
            if (bus.PSEL && bus.PENABLE) acc_len++;
            if (m == 0 && {m1_done, m1_err, m1_rdata} !== '0) o_bad = 1'b1;
            if (m == 1 && {m0_done, m0_err, m0_rdata} !== '0) o_bad = 1'b1;
            if ((m == 0 && m0_done) || (m == 1 && m1_done)) begin
                t_done = c; o_psel_done = bus.PSEL;
                o_rdata = (m == 0) ? m0_rdata : m1_rdata;
                o_err   = (m == 0) ? m0_err : m1_err;
                m0_req = 1'b0; m1_req = 1'b0;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        model_last = m;
    endtask

    // Both requesters raise reads together each round and hold until their own done.
    task automatic run_rounds(input int rounds);
        logic p0, p1;
        obs_order.delete(); setup_order.delete(); rr_bad = 0;
        for (int r = 0; r < rounds; r++) begin
            @(negedge PCLK);
            slave_waits = $urandom_range(0, 2); slave_rdata = $urandom; slave_err = 1'b0;
            m0_write = 1'b0; m0_addr = 32'h0000_0100; m0_strb = 4'(($urandom));
            m1_write = 1'b0; m1_addr = 32'h0000_0200; m1_strb = 4'(($urandom));
            m0_req = 1'b1; m1_req = 1'b1; p0 = 1'b1; p1 = 1'b1;
            for (int c = 0; c < 100 && (p0 || p1); c++) begin
                @(posedge PCLK); @(negedge PCLK);
                if (bus.PSEL && !bus.PENABLE) setup_order.push_back(bus.PADDR == 32'h0000_0200 ? 1 : 0);
                if (bus.PSEL && bus.PSTRB !== 4'h0) rr_bad++;
                if (m0_done && m1_done) rr_bad++;
                if (m0_done) begin
                    obs_order.push_back(0);
                    if (m0_rdata !== slave_rdata || m0_err !== 1'b0) rr_bad++;
                    m0_req = 1'b0; p0 = 1'b0;
                end
                if (m1_done) begin
                    obs_order.push_back(1);
                    if (m1_rdata !== slave_rdata || m1_err !== 1'b0) rr_bad++;
                    m1_req = 1'b0; p1 = 1'b0;
                end
            end
            m0_req = 1'b0; m1_req = 1'b0;
        end
    endtask

    // Reference arbitration: contention goes to the requester not served most recently.
    task automatic model_rounds(input int rounds);
        bit p0, p1;
        int g;
        exp_order.delete();
        for (int r = 0; r < rounds; r++) begin
            p0 = 1; p1 = 1;
            while (p0 || p1) begin
                g = (p0 && p1) ? 1 - model_last : (p0 ? 0 : 1);
                exp_order.push_back(g);
                model_last = g;
                if (g == 0) p0 = 0; else p1 = 0;
            end
        end
    endtask

    int t_sel, t_en, t_done, acc_len;
    logic [31:0] o_rdata, o_paddr, o_pwdata;
    logic [3:0] o_pstrb;
    logic o_err, o_bad, o_psel_done, o_pwrite;

    task automatic test_reset;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        checks++; if (bus.PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr got=%h exp=0", bus.PADDR); end
        checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL reset_pwdata got=%h exp=0", bus.PWDATA); end
        checks++; if (bus.PSTRB !== 4'h0) begin errors++; $display("FAIL reset_pstrb got=%h exp=0", bus.PSTRB); end
        checks++; if ({m0_done, m0_err, m0_rdata} !== 34'h0) begin errors++; $display("FAIL reset_m0 got=%h exp=0", {m0_done, m0_err, m0_rdata}); end
        checks++; if ({m1_done, m1_err, m1_rdata} !== 34'h0) begin errors++; $display("FAIL reset_m1 got=%h exp=0", {m1_done, m1_err, m1_rdata}); end
        PRESETn = 1'b1;
        model_last = 1;
    endtask

    task automatic test_write_basic;
        single(0, 1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF, 0, 32'hDEAD_BEEF, 1'b0,
               t_sel, t_en, t_done, acc_len, o_rdata, o_err, o_bad, o_psel_done, o_paddr, o_pstrb, o_pwdata, o_pwrite);
        checks++; if (t_sel !== 1) begin errors++; $display("FAIL wr_psel_cycle got=%0d exp=1", t_sel); end
        checks++; if (t_en !== 2) begin errors++; $display("FAIL wr_penable_cycle got=%0d exp=2", t_en); end
        checks++; if (t_done !== 3) begin errors++; $display("FAIL wr_done_cycle got=%0d exp=3", t_done); end
        checks++; if ({o_err, o_rdata} !== 33'h0) begin errors++; $display("FAIL wr_result got=%h exp=0", {o_err, o_rdata}); end
        checks++; if ({o_pwrite, o_paddr, o_pwdata, o_pstrb} !== {1'b1, 32'h4, 32'hA5, 4'hF}) begin
            errors++; $display("FAIL wr_bus got=%h exp=%h", {o_pwrite, o_paddr, o_pwdata, o_pstrb}, {1'b1, 32'h4, 32'hA5, 4'hF}); end
        checks++; if (o_bad !== 1'b0) begin errors++; $display("FAIL wr_stability got=%b exp=0", o_bad); end
        @(posedge PCLK); @(negedge PCLK);
        checks++; if ({m0_done, bus.PSEL} !== 2'b00) begin errors++; $display("FAIL wr_done_one_cycle got=%b exp=00", {m0_done, bus.PSEL}); end
    endtask

    task automatic test_random;
        int m, w;
        logic wr, se;
        logic [31:0] a, d, rd;
        logic [3:0] s;
        for (int i = 0; i < 10; i++) begin
            m = $urandom_range(0, 1); wr = 1'($urandom); se = 1'($urandom);
            w = $urandom_range(0, 6); a = $urandom; d = $urandom; rd = $urandom; s = 4'($urandom);
            single(m, wr, a, d, s, w, rd, se,
                   t_sel, t_en, t_done, acc_len, o_rdata, o_err, o_bad, o_psel_done, o_paddr, o_pstrb, o_pwdata, o_pwrite);
            checks++; if (t_done !== exp_acc_len(w) + 2) begin errors++; $display("FAIL rnd_done_cycle i=%0d got=%0d exp=%0d", i, t_done, exp_acc_len(w) + 2); end
            checks++; if (o_rdata !== (wr ? 32'h0 : rd)) begin errors++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, o_rdata, wr ? 32'h0 : rd); end
            checks++; if (o_err !== se) begin errors++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, o_err, se); end
            checks++; if ({o_paddr, o_pwrite, o_pstrb} !== {a, wr, (wr ? s : 4'h0)}) begin
                errors++; $display("FAIL rnd_bus i=%0d got=%h exp=%h", i, {o_paddr, o_pwrite, o_pstrb}, {a, wr, (wr ? s : 4'h0)}); end
            checks++; if (o_bad !== 1'b0) begin errors++; $display("FAIL rnd_stability i=%0d got=%b exp=0", i, o_bad); end
        end
    endtask

    task automatic test_round_robin;
        model_rounds(3);
        run_rounds(3);
        checks++; if (obs_order.size() !== exp_order.size()) begin errors++; $display("FAIL rr_count got=%0d exp=%0d", obs_order.size(), exp_order.size()); end
        for (int i = 0; i < exp_order.size() && i < obs_order.size(); i++) begin
            checks++; if (obs_order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, obs_order[i], exp_order[i]); end
        end
        checks++; if (setup_order.size() !== exp_order.size()) begin errors++; $display("FAIL rr_setups got=%0d exp=%0d", setup_order.size(), exp_order.size()); end
        for (int i = 0; i < exp_order.size() && i < setup_order.size(); i++) begin
            checks++; if (setup_order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_grant i=%0d got=%0d exp=%0d", i, setup_order[i], exp_order[i]); end
        end
        checks++; if (rr_bad !== 0) begin errors++; $display("FAIL rr_results got=%0d exp=0", rr_bad); end
    endtask

    task automatic test_wait_states;
        single(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0,
               t_sel, t_en, t_done, acc_len, o_rdata, o_err, o_bad, o_psel_done, o_paddr, o_pstrb, o_pwdata, o_pwrite);
        checks++; if (acc_len !== 4) begin errors++; $display("FAIL wait_access_len got=%0d exp=4", acc_len); end
        checks++; if (o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wait_rdata got=%h exp=12345678", o_rdata); end
        checks++; if ({o_err, o_pstrb} !== 5'h0) begin errors++; $display("FAIL wait_err_strb got=%h exp=0", {o_err, o_pstrb}); end
    endtask

    task automatic test_timeout;
        int wv[3];
        logic [31:0] rd;
        wv[0] = 255; wv[1] = TOUT - 1; wv[2] = TOUT - 2;
        for (int i = 0; i < 3; i++) begin
            rd = $urandom;
            single(0, 1'b0, 32'h0000_0080, 32'h0, 4'h3, wv[i], rd, 1'b0,
                   t_sel, t_en, t_done, acc_len, o_rdata, o_err, o_bad, o_psel_done, o_paddr, o_pstrb, o_pwdata, o_pwrite);
            checks++; if (acc_len !== exp_acc_len(wv[i])) begin errors++; $display("FAIL tout_len w=%0d got=%0d exp=%0d", wv[i], acc_len, exp_acc_len(wv[i])); end
            checks++; if (o_err !== (wv[i] >= TOUT)) begin errors++; $display("FAIL tout_err w=%0d got=%b exp=%b", wv[i], o_err, wv[i] >= TOUT); end
            checks++; if (o_rdata !== ((wv[i] >= TOUT) ? 32'h0 : rd)) begin errors++; $display("FAIL tout_rdata w=%0d got=%h exp=%h", wv[i], o_rdata, (wv[i] >= TOUT) ? 32'h0 : rd); end
            checks++; if (o_psel_done !== 1'b0) begin errors++; $display("FAIL tout_psel_done w=%0d got=%b exp=0", wv[i], o_psel_done); end
        end
    endtask

    task automatic test_slverr;
        single(0, 1'b0, 32'h0000_00C0, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b1,
               t_sel, t_en, t_done, acc_len, o_rdata, o_err, o_bad, o_psel_done, o_paddr, o_pstrb, o_pwdata, o_pwrite);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL slverr_m0 got=%b exp=1", o_err); end
        single(1, 1'b1, 32'h0000_00C4, 32'h5555_AAAA, 4'h6, 0, 32'h7777_7777, 1'b0,
               t_sel, t_en, t_done, acc_len, o_rdata, o_err, o_bad, o_psel_done, o_paddr, o_pstrb, o_pwdata, o_pwrite);
        checks++; if ({o_err, o_rdata} !== 33'h0) begin errors++; $display("FAIL slverr_m1_after got=%h exp=0", {o_err, o_rdata}); end
    endtask

    task automatic test_reset_mid_access;
        int seen_en, done_seen;
        @(negedge PCLK);
        slave_waits = 255; seen_en = 0; done_seen = 0;
        m0_write = 1'b1; m0_addr = 32'h0000_0300; m0_wdata = 32'hCAFE_0001; m0_strb = 4'hF; m0_req = 1'b1;
        for (int c = 0; c < 10 && seen_en == 0; c++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (bus.PENABLE) seen_en = 1;
        end
        checks++; if (seen_en !== 1) begin errors++; $display("FAIL rst_mid_reach_access got=%0d exp=1", seen_en); end
        @(posedge PCLK); @(negedge PCLK);
        PRESETn = 1'b0; m0_req = 1'b0;
        #1;
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got=%h exp=0", {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PSTRB, m0_done, m0_rdata, m1_done, m1_rdata}); end
        for (int c = 0; c < 4; c++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (m0_done || m1_done) done_seen++;
            if (c == 1) PRESETn = 1'b1;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_seen); end
        model_last = 1;
        model_rounds(1);
        run_rounds(1);
        checks++; if (obs_order.size() !== 2) begin errors++; $display("FAIL rst_mid_count got=%0d exp=2", obs_order.size()); end
        checks++; if (obs_order.size() > 0 && obs_order[0] !== exp_order[0]) begin errors++; $display("FAIL rst_mid_first_grant got=%0d exp=%0d", obs_order[0], exp_order[0]); end
        checks++; if (rr_bad !== 0) begin errors++; $display("FAIL rst_mid_results got=%0d exp=0", rr_bad); end
    endtask

    initial begin
        m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
        test_reset;
        test_write_basic;
        test_random;
        test_round_robin;
        test_wait_states;
        test_timeout;
        test_slverr;
        test_reset_mid_access;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, width of PADDR and requester address fields.
REQ-002 Parameter DATA_W, 32, width of write and read data; strobe width is DATA_W/8.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS-phase cycles without PREADY before the transfer is aborted; legal range 2..255.
REQ-004 PCLK  in  1  single system clock; all state updates on the rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 mN_req  in  1  transfer request from requester N (N=0,1); held high until mN_done.
REQ-007 mN_addr / mN_write / mN_wdata / mN_strb  in  ADDR_W/1/DATA_W/DATA_W/8  transfer fields; held stable while mN_req is high.
REQ-008 mN_done  out  1  one-cycle pulse marking completion of requester N's transfer.
REQ-009 mN_rdata / mN_err  out  DATA_W/1  read data and error result, valid only while mN_done=1.
REQ-010 PSEL, PENABLE, PWRITE  out  1  APB control to the address decoder and slaves.
REQ-011 PADDR / PWDATA / PSTRB  out  ADDR_W/DATA_W/DATA_W/8  APB address, write data and strobes.
REQ-012 PREADY, PSLVERR  in  1  APB slave completion and error.
REQ-013 PRDATA  in  DATA_W  APB read data.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SETUP, ACCESS and DONE.
REQ-015 All outputs SHALL be driven from registers.
REQ-016 In IDLE with at least one mN_req high, the block SHALL grant one requester, latch that requester's fields into the APB output registers, and enter SETUP.
REQ-017 Arbitration SHALL be round-robin: when both requesters are high, the grant goes to the requester not granted most recently; a single requester is granted immediately regardless of history.
REQ-018 mN_req SHALL be sampled only in IDLE; a request raised in any other state waits and is not lost.
REQ-019 SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0, then enter ACCESS.
REQ-020 In ACCESS, PSEL=1 and PENABLE=1; PADDR, PWRITE, PWDATA and PSTRB SHALL stay constant from SETUP to the end of ACCESS.
REQ-021 When PREADY=1 in ACCESS, the block SHALL capture PRDATA and PSLVERR, drop PSEL and PENABLE, and enter DONE.
REQ-022 In DONE, the granted mN_done SHALL be high for exactly one cycle, with mN_rdata equal to the captured PRDATA and mN_err equal to the captured PSLVERR; the block then returns to IDLE.
REQ-023 On a write, mN_rdata SHALL be 0.
REQ-024 A wait counter SHALL count ACCESS cycles with PREADY=0; if it reaches TIMEOUT-1 with PREADY still 0, the block SHALL abort: drop PSEL and PENABLE, enter DONE with mN_err=1 and mN_rdata=0.
REQ-025 If PREADY=1 in the same cycle the timeout would fire, the block SHALL treat it as a normal completion.
REQ-026 The non-granted requester's done, rdata and err outputs SHALL stay 0 at all times.
REQ-027 Latency: request seen in IDLE at edge k -> SETUP in cycle k+1, ACCESS in k+2; with zero-wait PREADY, done is high in k+3 and the block is in IDLE in k+4.
REQ-028 A requester SHALL deassert mN_req, or present new fields for a back-to-back transfer, by the cycle after mN_done; the block samples again at the next IDLE.
REQ-029 PSTRB SHALL be driven as 0 for read transfers.

Reset
REQ-030 When PRESETn=0, the block SHALL asynchronously force the state to IDLE, drive all outputs to 0, clear the wait counter, and set last-grant to requester 1, so requester 0 wins the first contention.
REQ-031 A reset during SETUP or ACCESS SHALL abandon the transfer without issuing mN_done; operation resumes in IDLE on the first edge after PRESETn rises.

Verification
REQ-032 m0 write, addr 0x0000_0004, wdata 0xA5, strb 0xF, PREADY tied 1 -> PSEL rises in k+1, PENABLE in k+2, m0_done in k+3 with m0_err=0, m0_rdata=0.
REQ-033 m0 and m1 reads raised in the same cycle, repeated 3 times -> grant order m0, m1, m0, m1, m0, m1, with no overlapping PSEL periods.
REQ-034 m1 read with PREADY delayed 3 cycles and PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles and m1_rdata=0x1234_5678.
REQ-035 PREADY held 0 with TIMEOUT=16 -> abort after exactly 16 ACCESS cycles with m0_err=1, m0_rdata=0, and PSEL low in DONE.
REQ-036 PSLVERR=1 with PREADY -> m0_err=1; a subsequent m1 transfer completes with m1_err=0.
REQ-037 PRESETn pulsed low mid-ACCESS -> all outputs 0 immediately, no done pulse, and the next request is served normally with m0 priority.
